// File: rtl/tx_pkg.sv
// Shared types for the TX FFE driver: FSM states, NRZ symbols and the
// PWL segment descriptor handed to the channel model.
package tx_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  typedef logic signed [1:0]  sym_t;    // -1, 0 (idle), +1
  typedef logic signed [15:0] lvl_t;    // level in mV
  typedef logic signed [31:0] slope_t;  // slope in uV per ps
  typedef logic        [31:0] tps_t;    // time in ps

  localparam sym_t SYM_IDLE = '0;

  // Segment: v(t) = a + b*(t-t0)/1000 for t0 <= t < t1, then v(t) = y.
  typedef struct packed {
    lvl_t   a;
    slope_t b;
    tps_t   t0;
    tps_t   t1;
    lvl_t   y;
  } pwl_t;

  function automatic sym_t sym_map(input logic bit_i);
    return bit_i ? 2'sb01 : 2'sb11;
  endfunction

endpackage

// File: rtl/pwl_ramp.sv
// Turns a clock-timed target level into linear PWL segments of fixed edge
// time, restarting from the instantaneous value when a new target arrives.
module pwl_ramp
  import tx_pkg::*;
#(
  parameter int T_EDGE_PS = 20,
  parameter int T_CLK_PS  = 100,
  parameter int ETOL_UV   = 1000
) (
  input  logic clk,
  input  lvl_t target_i,
  output pwl_t out_o
);

  if (T_EDGE_PS <= 0 || T_EDGE_PS >= T_CLK_PS) begin : g_bad_edge
    $fatal(1, "pwl_ramp: edge time must be positive and shorter than the clock period");
  end
  // Slope LSB is 1 uV/ps, so worst-case quantisation over a ramp is T_EDGE_PS uV.
  if (T_EDGE_PS > ETOL_UV) begin : g_bad_tol
    $fatal(1, "pwl_ramp: slope quantisation exceeds the PWL error tolerance");
  end

  pwl_t               seg_q, seg_d;
  tps_t               now_q;
  tps_t               elapsed;
  lvl_t               present;
  logic signed [47:0] ramp_uv;
  logic signed [31:0] delta;

  always_comb begin
    elapsed = now_q - seg_q.t0;
    ramp_uv = 48'($signed(seg_q.b)) * 48'($signed({1'b0, elapsed[15:0]}));
    if (elapsed >= tps_t'(T_EDGE_PS)) begin
      present = seg_q.y;
    end else begin
      present = lvl_t'(48'($signed(seg_q.a)) + ramp_uv / 48'sd1000);
    end
    delta = 32'($signed(target_i)) - 32'($signed(present));
    seg_d = seg_q;
    if (target_i != seg_q.y) begin
      seg_d.a  = present;
      seg_d.b  = slope_t'((delta * 32'sd1000) / T_EDGE_PS);
      seg_d.t0 = now_q;
      seg_d.t1 = now_q + tps_t'(T_EDGE_PS);
      seg_d.y  = target_i;
    end
  end

  // Not reset: a reset mid-ramp must continue from the instantaneous level,
  // and the timebase origin is irrelevant since only differences matter.
  always_ff @(posedge clk) begin
    seg_q <= seg_d;
    now_q <= now_q + tps_t'(T_CLK_PS);
  end

  assign out_o = seg_q;

endmodule

// File: rtl/tx_ffe_driver.sv
// Transmit front end: valid/ready word intake, LSB-first serializer,
// 3-tap FFE on NRZ symbols and a finite-edge PWL output.
module tx_ffe_driver
  import tx_pkg::*;
#(
  parameter int W         = 8,
  parameter int AMP_MV    = 500,
  parameter int C_PRE     = -100,  // coefficients in units of 1/1000
  parameter int C_MAIN    = 700,
  parameter int C_POST    = -200,
  parameter int T_EDGE_PS = 20,
  parameter int T_CLK_PS  = 100,
  parameter int ETOL_UV   = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         en,
  output logic         underrun,
  output pwl_t         out
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam int COEF_L1 = (C_PRE  < 0 ? -C_PRE  : C_PRE)
                         + (C_MAIN < 0 ? -C_MAIN : C_MAIN)
                         + (C_POST < 0 ? -C_POST : C_POST);

  if (W < 2) begin : g_bad_w
    $fatal(1, "tx_ffe_driver: word width must be at least 2");
  end
  if (COEF_L1 > 1000) begin : g_bad_coef
    $fatal(1, "tx_ffe_driver: sum of |FFE coefficients| exceeds 1.0");
  end

  state_t             state_q;
  logic [W-1:0]       hold_q, shreg_q;
  logic               hold_full_q;
  logic [CW-1:0]      bit_cnt_q;
  logic               underrun_q;
  sym_t               pre_q, main_q, post_q;
  sym_t               pre_d, main_d, post_d;
  logic signed [31:0] acc;
  lvl_t               target;
  logic               xfer;

  // A word in its last bit slot frees the hold register this cycle.
  assign din_ready = !rst && en &&
                     (state_q == IDLE || (state_q == SHIFT && bit_cnt_q == LAST) || !hold_full_q);
  assign xfer      = din_valid && din_ready;
  assign underrun  = underrun_q;

  always_comb begin
    pre_d  = (state_q == SHIFT) ? sym_map(shreg_q[0]) : SYM_IDLE;
    main_d = pre_q;
    post_d = main_q;
    acc    = C_PRE * 32'(pre_d) + C_MAIN * 32'(main_d) + C_POST * 32'(post_d);
    target = rst ? '0 : lvl_t'((AMP_MV * acc) / 1000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      underrun_q  <= 1'b0;
      pre_q       <= SYM_IDLE;
      main_q      <= SYM_IDLE;
      post_q      <= SYM_IDLE;
    end else begin
      pre_q      <= pre_d;
      main_q     <= main_d;
      post_q     <= post_d;
      underrun_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            hold_q      <= din;
            hold_full_q <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          shreg_q     <= hold_q;
          hold_full_q <= 1'b0;
          bit_cnt_q   <= '0;
          state_q     <= SHIFT;
        end
        SHIFT: begin
          shreg_q   <= shreg_q >> 1;
          bit_cnt_q <= bit_cnt_q + CW'(1);
          if (bit_cnt_q != LAST) begin
            if (xfer) begin
              hold_q      <= din;
              hold_full_q <= 1'b1;
            end
          end else if (en && hold_full_q) begin
            shreg_q     <= hold_q;
            hold_q      <= din;
            hold_full_q <= xfer;
            bit_cnt_q   <= '0;
          end else if (xfer) begin
            shreg_q   <= din;
            bit_cnt_q <= '0;
          end else begin
            // Drain; with en low any held word is dropped silently.
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            underrun_q  <= en;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  pwl_ramp #(
    .T_EDGE_PS(T_EDGE_PS),
    .T_CLK_PS (T_CLK_PS),
    .ETOL_UV  (ETOL_UV)
  ) u_ramp (
    .clk     (clk),
    .target_i(target),
    .out_o   (out)
  );

endmodule

// File: tb/tb_tx_ffe_driver.sv
// Directed bench: one unit-gain instance (c_main=1) and one default-FFE
// instance share the same stimulus; expected levels are hand-computed.
module tb_tx_ffe_driver;
  import tx_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       en;
  logic       rdy_u, rdy_d, und_u, und_d;
  pwl_t       out_u, out_d;

  int n_vec = 0;
  int n_err = 0;

  pwl_t su [64];
  pwl_t sd [64];
  int   n_rdy_low, n_und_u, n_und_d;

  tx_ffe_driver #(
    .W(8), .AMP_MV(500), .C_PRE(0), .C_MAIN(1000), .C_POST(0),
    .T_EDGE_PS(20), .T_CLK_PS(100), .ETOL_UV(1000)
  ) u_unit (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_u),
    .en(en), .underrun(und_u), .out(out_u)
  );

  tx_ffe_driver #(
    .W(8)
  ) u_dflt (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_d),
    .en(en), .underrun(und_d), .out(out_d)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Offers up to three words with valid held high; sample i is taken just
  // after edge k+i, where k is the edge accepting the first word.
  task automatic run_stream(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input int nw, input int ncyc, input int en_drop);
    logic [7:0] words [3];
    int         idx;
    logic       go;
    words[0] = w0; words[1] = w1; words[2] = w2;
    idx = 0; n_rdy_low = 0; n_und_u = 0; n_und_d = 0;
    din = words[0];
    din_valid = (nw > 0);
    for (int i = 0; i < ncyc; i++) begin
      go = din_valid && rdy_u;
      @(negedge clk);
      if (go) begin
        idx++;
        din_valid = (idx < nw);
        if (idx < nw) din = words[idx];
      end
      if (i == en_drop) en = 1'b0;
      su[i] = out_u;
      sd[i] = out_d;
      if (!rdy_u) n_rdy_low++;
      if (und_u) n_und_u++;
      if (und_d) n_und_d++;
    end
    din_valid = 1'b0;
  endtask

  int exp_a5 [8] = '{500, -500, 500, -500, -500, 500, -500, 500};
  int exp_3c [8] = '{-500, -500, 500, 500, 500, 500, -500, -500};
  // Default FFE, words 00,01,00: samples i=2..28.
  int exp_ffe [27] = '{50, -300, -200, -200, -200, -200, -200, -200, -300, 500, -400,
                       -200, -200, -200, -200, -200, -200, -200, -200, -200, -200, -200,
                       -200, -200, -250, 100, 0};

  initial begin
    rst = 1'b1; en = 1'b1; din_valid = 1'b1; din = 8'h5A;

    // Reset held 3 clocks with valid high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_ready_u[%0d]", i), rdy_u, 0);
      check($sformatf("rst_ready_d[%0d]", i), rdy_d, 0);
      check($sformatf("rst_underrun[%0d]", i), und_u, 0);
    end
    check("rst_out_a", $signed(out_u.a), 0);
    check("rst_out_b", $signed(out_u.b), 0);
    check("rst_out_y", $signed(out_u.y), 0);
    rst = 1'b0; din_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_y[%0d]", i), $signed(out_u.y), 0);
      check($sformatf("post_rst_und[%0d]", i), und_u, 0);
    end

    // Single word A5, unit gain.
    run_stream(8'hA5, 8'h00, 8'h00, 1, 14, -1);
    for (int i = 0; i < 14; i++)
      check($sformatf("a5_y[%0d]", i), $signed(su[i].y), (i >= 3 && i <= 10) ? exp_a5[i-3] : 0);
    check("a5_underruns", n_und_u, 1);
    check("a5_und_slot", und_u, 0);
    check("a5_ramp0_a", $signed(su[3].a), 0);
    check("a5_ramp0_b", $signed(su[3].b), 25000);
    check("a5_ramp0_len", su[3].t1 - su[3].t0, 20);
    check("a5_ramp1_a", $signed(su[4].a), 500);
    check("a5_ramp1_b", $signed(su[4].b), -50000);
    check("a5_evt_step", su[6].t0 - su[5].t0, 100);
    check("a5_no_evt_same_lvl", su[8].t0 - su[6].t0, 200);

    // Back-to-back FF,00,FF.
    run_stream(8'hFF, 8'h00, 8'hFF, 3, 30, -1);
    for (int i = 3; i < 30; i++)
      check($sformatf("b2b_y[%0d]", i), $signed(su[i].y),
            (i > 26) ? 0 : ((i - 3 >= 8 && i - 3 < 16) ? -500 : 500));
    check("b2b_ready_low", n_rdy_low, 14);
    check("b2b_underruns", n_und_u, 1);

    // Default FFE levels, words 00,01,00.
    run_stream(8'h00, 8'h01, 8'h00, 3, 29, -1);
    for (int i = 2; i < 29; i++)
      check($sformatf("ffe_y[%0d]", i), $signed(sd[i].y), exp_ffe[i-2]);
    check("ffe_main_slope", $signed(sd[11].b), 40000);
    check("ffe_post_slope", $signed(sd[12].b), -45000);
    check("ffe_underruns", n_und_d, 1);

    // en drops during the first word; queued F0 must be flushed.
    run_stream(8'h0F, 8'hF0, 8'h00, 2, 16, 4);
    for (int i = 3; i < 16; i++)
      check($sformatf("en_y[%0d]", i), $signed(su[i].y),
            (i > 10) ? 0 : ((i < 7) ? 500 : -500));
    check("en_underruns", n_und_u, 0);
    en = 1'b1;

    // Reset while bit 3 is the main cursor.
    run_stream(8'hA5, 8'h00, 8'h00, 1, 7, -1);
    check("mid_bit3_y", $signed(su[6].y), -500);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_y", $signed(out_u.y), 0);
    check("mid_rst_a", $signed(out_u.a), -500);
    check("mid_rst_b", $signed(out_u.b), 25000);
    check("mid_rst_len", out_u.t1 - out_u.t0, 20);
    check("mid_rst_ready", rdy_u, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("mid_after_y[%0d]", i), $signed(out_u.y), 0);
      check($sformatf("mid_after_und[%0d]", i), und_u, 0);
    end
    run_stream(8'h3C, 8'h00, 8'h00, 1, 14, -1);
    check("clean_start_a", $signed(su[3].a), 0);
    for (int i = 0; i < 14; i++)
      check($sformatf("clean_y[%0d]", i), $signed(su[i].y), (i >= 3 && i <= 10) ? exp_3c[i-3] : 0);
    check("clean_underruns", n_und_u, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
